alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Arithmetic/logic stage directly downstream of the accumulator in the 16-bit SAP datapath.
- Consumes the accumulator output (aout) as operand A and holds operand B in an internal B register loaded from the shared bus.
- Executes single-cycle ops with 1-cycle latency, and a multi-cycle shift-add multiply.
- Presents a registered result (alu_out) for the bus driver and a registered flags nibble for the controller's branch logic.

Parameters:
- WIDTH, 16, datapath width of operands, B register and result.
- MUL_CYCLES, WIDTH, number of iteration cycles of the multiply (one per multiplier bit).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- bus  input  WIDTH  shared bus; source for the B register.
- b_write  input  1  load B register from bus on a clock edge.
- aout  input  WIDTH  accumulator value, operand A.
- alu_op  input  3  operation select, sampled with alu_start.
- alu_start  input  1  start request, sampled only in IDLE.
- alu_out  output  WIDTH  registered result.
- flags  output  4  registered {Z, C, N, V}.
- alu_busy  output  1  high while a multiply is in progress.
- alu_done  output  1  one-cycle pulse when alu_out and flags are updated.
- b_out  output  WIDTH  current B register value, for debug/bus readback.

Behaviour:
- Reset, asynchronous and active-high: alu_out=0, flags=0, alu_busy=0, alu_done=0, B=0, FSM=IDLE, multiply working registers cleared.
- B register: loads bus on any clock edge where b_write=1, including while busy. An in-flight multiply uses its own snapshot and is unaffected.
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 SHL: A<<1, LSB filled with 0
  - 111 MUL: low WIDTH bits of A*B, unsigned
- FSM states: IDLE, MUL, DONE.
  - IDLE, alu_start=1, op≠111: result and flags registered at that edge. Next state DONE, so alu_done is high for exactly the following cycle. Latency is 1 edge.
  - IDLE, alu_start=1, op=111: snapshot A, B and op at that edge; clear the 2*WIDTH product accumulator; alu_busy=1; next state MUL.
  - MUL: one iteration per edge (if multiplier LSB is set, add the shifted multiplicand; shift multiplicand left and multiplier right). After MUL_CYCLES edges, register the low WIDTH product bits and flags, drop alu_busy, go to DONE. alu_done is high in the cycle after edge start+MUL_CYCLES.
  - DONE: alu_done=1 for one cycle, then unconditional return to IDLE. alu_start here is ignored; the controller re-asserts it.
- alu_start while in MUL or DONE is ignored; no queuing.
- alu_out and flags hold their last values between operations and change only on completion edges.
- Flag rules:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C:
    - ADD: carry-out.
    - SUB: borrow (1 when A<B unsigned).
    - SHL: A[WIDTH-1].
    - MUL: 1 if the upper WIDTH product bits are nonzero.
    - Logic ops and NOT: 0.
  - V: signed overflow for ADD/SUB, 0 for all other ops.
- Reset asserted mid-multiply aborts immediately: outputs go to reset values and no alu_done is produced.
- Simultaneous b_write and alu_start: the op uses the old B value (pre-edge register), and B takes bus.

Test Plan:
- B←200, aout=300, ADD → alu_out=500 (16'h01F4), flags Z0 C0 N0 V0; alu_done high 1 cycle after start edge.
- B←300, aout=200, SUB → alu_out=16'hFF9C, C=1, N=1, Z=0, V=0.
- aout=16'hFFFF, B=1, ADD → alu_out=0, Z=1, C=1, V=0. Then aout=16'h7FFF, B=1, ADD → 16'h8000, N=1, V=1, C=0.
- aout=300, B=200, MUL → alu_busy high for 16 cycles; alu_out=16'hEA60 (60000), C=0; alu_done exactly one cycle. alu_start pulses during busy are ignored, and b_write during busy leaves the result unchanged.
- aout=300, B=300, MUL → alu_out=16'h5F90 (90000 mod 65536), C=1, Z=0.
- Start MUL, assert rst at iteration 8 for 3 ns between edges → alu_out=0, flags=0, alu_busy=0, no alu_done; a subsequent AND of 16'hDEDE with 16'h00FF gives 16'h00DE.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: groups the bus-side and controller-side signals of the
// arithmetic/logic stage.
//   master : drives bus, b_write, aout, alu_op, alu_start (controller/datapath)
//   slave  : the ALU; drives alu_out, flags, alu_busy, alu_done, b_out
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] bus;
  logic             b_write;
  logic [WIDTH-1:0] aout;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       flags;
  logic             alu_busy;
  logic             alu_done;
  logic [WIDTH-1:0] b_out;

  modport master (
    output bus, b_write, aout, alu_op, alu_start,
    input  alu_out, flags, alu_busy, alu_done, b_out
  );

  modport slave (
    input  bus, b_write, aout, alu_op, alu_start,
    output alu_out, flags, alu_busy, alu_done, b_out
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: arithmetic/logic stage downstream of the accumulator.
// Operand A is the accumulator value (aout); operand B is held in an internal
// register loaded from the shared bus. Single-cycle ops complete on the start
// edge; MUL is a shift-add multiply taking MUL_CYCLES iteration edges.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   alu.bus    shared bus, source for B       alu.b_write  load B
//   alu.aout   operand A                      alu.alu_op   op select
//   alu.alu_start  start request (IDLE only)
//   alu.alu_out    registered result          alu.flags    registered {Z,C,N,V}
//   alu.alu_busy   multiply in progress       alu.alu_done one-cycle completion pulse
//   alu.b_out      current B register
module alu_seq #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  alu
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   alu_out_r;
  logic [3:0]         flags_r;

  // Multiply working registers: shifted multiplicand, remaining multiplier
  // bits, running product and iteration count.
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] prod_nx;
  logic               mul_last;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;

  logic               sc_load;
  logic               mul_load;
  logic               mul_fin;

  // Single-cycle result and C/V flags from live A and the pre-edge B register.
  always_comb begin
    sum    = {1'b0, alu.aout} + {1'b0, b_reg};
    diff   = {1'b0, alu.aout} - {1'b0, b_reg};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op_t'(alu.alu_op))
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (alu.aout[WIDTH-1] == b_reg[WIDTH-1]) &&
                 (sum[WIDTH-1] != alu.aout[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        // Bit WIDTH of the widened difference is the borrow (A < B unsigned).
        sc_c   = diff[WIDTH];
        sc_v   = (alu.aout[WIDTH-1] != b_reg[WIDTH-1]) &&
                 (diff[WIDTH-1] != alu.aout[WIDTH-1]);
      end
      OP_AND: sc_res = alu.aout & b_reg;
      OP_OR:  sc_res = alu.aout | b_reg;
      OP_XOR: sc_res = alu.aout ^ b_reg;
      OP_NOT: sc_res = ~alu.aout;
      OP_SHL: begin
        sc_res = {alu.aout[WIDTH-2:0], 1'b0};
        sc_c   = alu.aout[WIDTH-1];
      end
      default: begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
      end
    endcase
  end

  // One shift-add step; on the final iteration this value is also the
  // completed product, so the result is registered from it directly.
  always_comb begin
    prod_nx  = prod + (mplier[0] ? mcand : '0);
    mul_last = (cnt == CW'(MUL_CYCLES - 1));
  end

  // Next-state and load strobes.
  always_comb begin
    state_nx = state;
    sc_load  = 1'b0;
    mul_load = 1'b0;
    mul_fin  = 1'b0;
    case (state)
      IDLE: begin
        if (alu.alu_start) begin
          if (op_t'(alu.alu_op) == OP_MUL) begin
            mul_load = 1'b1;
            state_nx = MUL;
          end else begin
            sc_load  = 1'b1;
            state_nx = DONE;
          end
        end
      end
      MUL: begin
        if (mul_last) begin
          mul_fin  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_reg     <= '0;
      alu_out_r <= '0;
      flags_r   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      if (alu.b_write) begin
        b_reg <= alu.bus;
      end

      if (mul_load) begin
        mcand  <= {{WIDTH{1'b0}}, alu.aout};
        mplier <= b_reg;
        prod   <= '0;
        cnt    <= '0;
      end else if (state == MUL) begin
        prod   <= prod_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end

      if (sc_load) begin
        alu_out_r <= sc_res;
        flags_r   <= {~|sc_res, sc_c, sc_res[WIDTH-1], sc_v};
      end else if (mul_fin) begin
        alu_out_r <= prod_nx[WIDTH-1:0];
        flags_r   <= {~|prod_nx[WIDTH-1:0], |prod_nx[2*WIDTH-1:WIDTH],
                      prod_nx[WIDTH-1], 1'b0};
      end
    end
  end

  assign alu.alu_out  = alu_out_r;
  assign alu.flags    = flags_r;
  assign alu.alu_busy = (state == MUL);
  assign alu.alu_done = (state == DONE);
  assign alu.b_out    = b_reg;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W  = 16;
  localparam int MC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) alu ();

  alu_seq #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst),
    .alu (alu)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [19:0]     sb[$];
  logic [W-1:0]    b_model = '0;
  logic            done_prev = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Reference: plain integer arithmetic; returns {result, Z, C, N, V}.
  function automatic logic [19:0] model(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [2:0] op);
    longint ua, ub, p, s, sa, sbv;
    logic [W-1:0] r;
    logic c, v;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = (ua >= 32768) ? ua - 65536 : ua;
    sbv = (ub >= 32768) ? ub - 65536 : ub;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = ua + ub; r = 16'(s % 65536); c = (s > 65535);
        s = sa + sbv; v = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        s = ua - ub + 65536; r = 16'(s % 65536); c = (ua < ub);
        s = sa - sbv; v = (s > 32767) || (s < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin s = ua * 2; r = 16'(s % 65536); c = (ua >= 32768); end
      default: begin p = ua * ub; r = 16'(p % 65536); c = (p >= 65536); end
    endcase
    return {r, (r == 16'd0), c, r[W-1], v};
  endfunction

  // Monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu.alu_done) begin
        chk("done_one_cycle", 32'(done_prev), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [19:0] e;
          e = sb.pop_front();
          chk("result_flags", {12'd0, alu.alu_out, alu.flags}, {12'd0, e});
        end
      end
      done_prev = alu.alu_done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic load_b(input logic [W-1:0] v);
    alu.bus = v; alu.b_write = 1'b1;
    @(posedge clk); #1;
    alu.b_write = 1'b0;
    b_model = v;
    chk("b_out", 32'(alu.b_out), 32'(v));
  endtask

  // Issue one op and wait (bounded) for completion; checks latency and busy.
  task automatic run_op(input logic [W-1:0] a, input logic [2:0] op,
                        input bit noise, input bit bw, input logic [W-1:0] bv);
    int unsigned n, bsy;
    bit got, pend;
    logic [W-1:0] pv;
    alu.aout = a; alu.alu_op = op; alu.alu_start = 1'b1;
    alu.b_write = bw; alu.bus = bv;
    sb.push_back(model(a, b_model, op));
    @(posedge clk); #1;
    if (bw) b_model = bv;
    alu.alu_start = 1'b0; alu.b_write = 1'b0;
    n = 0; bsy = 0; got = 1'b0; pend = 1'b0; pv = '0;
    while (!got && n <= MC + 4) begin
      @(negedge clk);
      if (alu.alu_done) begin
        got = 1'b1;
      end else begin
        if (alu.alu_busy) bsy++;
        if (noise && n < MC - 1) begin
          alu.alu_start = 1'b1;
          alu.alu_op    = 3'($urandom);
          alu.aout      = 16'($urandom);
          alu.b_write   = 1'($urandom);
          alu.bus       = 16'($urandom);
          pend = alu.b_write; pv = alu.bus;
        end
        @(posedge clk); #1;
        n++;
        if (pend) b_model = pv;
        pend = 1'b0;
        alu.alu_start = 1'b0; alu.b_write = 1'b0;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", n, (op == 3'd7) ? MC : 0);
    chk("busy_cycles", bsy, (op == 3'd7) ? MC : 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned dn;
    alu.bus = '0; alu.b_write = 1'b0; alu.aout = '0;
    alu.alu_op = '0; alu.alu_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",   32'(alu.alu_out),  32'd0);
    chk("rst_flags", 32'(alu.flags),    32'd0);
    chk("rst_busy",  32'(alu.alu_busy), 32'd0);
    chk("rst_done",  32'(alu.alu_done), 32'd0);
    chk("rst_b",     32'(alu.b_out),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    load_b(16'd200); run_op(16'd300, 3'd0, 0, 0, '0);
    chk("add_hold", 32'(alu.alu_out), 32'h01F4);
    load_b(16'd300); run_op(16'd200, 3'd1, 0, 0, '0);
    load_b(16'd1);   run_op(16'hFFFF, 3'd0, 0, 0, '0);
    run_op(16'h7FFF, 3'd0, 0, 0, '0);
    load_b(16'd200); run_op(16'd300, 3'd7, 1, 0, '0);
    load_b(16'd300); run_op(16'd300, 3'd7, 0, 0, '0);
    chk("mul_hold", 32'(alu.alu_out), 32'h5F90);
    run_op(16'h8001, 3'd6, 0, 0, '0);
    // Simultaneous load and start: op sees old B.
    run_op(16'h1234, 3'd1, 0, 1, 16'h0F0F);
    run_op(16'h1234, 3'd4, 0, 0, '0);
    run_op(16'h00F0, 3'd5, 0, 0, '0);

    // Reset in the middle of a multiply.
    load_b(16'd200);
    alu.aout = 16'd300; alu.alu_op = 3'd7; alu.alu_start = 1'b1;
    @(posedge clk); #1;
    alu.alu_start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("abort_out",   32'(alu.alu_out),  32'd0);
    chk("abort_flags", 32'(alu.flags),    32'd0);
    chk("abort_busy",  32'(alu.alu_busy), 32'd0);
    chk("abort_b",     32'(alu.b_out),    32'd0);
    #1 rst = 1'b0;
    b_model = '0;
    dn = 0;
    repeat (24) begin
      @(negedge clk);
      if (alu.alu_done) dn++;
    end
    chk("abort_no_done", dn, 0);
    @(posedge clk); #1;
    load_b(16'h00FF); run_op(16'hDEDE, 3'd2, 0, 0, '0);
    chk("and_hold", 32'(alu.alu_out), 32'h00DE);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      if ($urandom_range(0, 2) == 0) load_b(16'($urandom));
      op = 3'($urandom);
      run_op(16'($urandom), op, (op == 3'd7), ($urandom_range(0, 3) == 0),
             16'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
